issue_ex_pipe_stage: RTL and testbench
======================================

// Module: issue_ex_pipe_stage
// PURPOSE
//  Parametrised issue->EX pipeline stage for the N-wide in-order core. It replaces the fixed
//  two-lane issue/EX1 register and adds a valid/ready handshake, a 2-entry skid buffer
//  (main + skid), per-lane kill (nop) and per-lane valid bits.
//  Sits between the issue logic (upstream) and the EX1 lanes (downstream).
// PARAMETERS
//  LANES   2   issue width (number of lanes), >=1
//  DATA_W  32  width of instr/imm/pc fields
//  REG_W   5   width of rs1/rs2/rd address fields
//  PAY_W   3*DATA_W+3*REG_W+1   per-lane payload width (derived; do not override)
//  CNT_W   32  perf-counter width (only with ISSUE_PERF_CNT_EN)
// PORTS
//  clk          in   1            clock, all state on posedge
//  rstn         in   1            asynchronous active-low reset
//  flush        in   1            pipeline flush (OR of branch-resolve flushes)
//  in_valid     in   1            upstream group valid
//  in_ready     out  1            stage can accept a group (= !skid_full, registered source)
//  in_lane_vld  in   LANES        per-lane instruction present
//  in_nop       in   LANES        per-lane kill: lane enters as bubble
//  in_payload   in   LANES*PAY_W  lane i at [i*PAY_W +: PAY_W]; field layout per ISSUE_PAY_* offsets
//  out_valid    out  1            main entry holds a group
//  out_ready    in   1            EX1 accepts (0 = stall)
//  out_lane_vld out  LANES        per-lane valid of main entry
//  out_payload  out  LANES*PAY_W  main-entry payload; lane zero when its out_lane_vld=0
//  perf_stall_cnt  out CNT_W      [ISSUE_PERF_CNT_EN only] cycles out_valid&!out_ready
//  perf_bubble_cnt out CNT_W      [ISSUE_PERF_CNT_EN only] cycles !out_valid
//  perf_kill_cnt   out CNT_W      [ISSUE_PERF_CNT_EN only] lanes killed on accept
// BEHAVIOUR
//  - Reset: state EMPTY, all entries/payloads/lane valids 0, out_valid=0, in_ready=1, counters 0.
//  - Accept = in_valid & in_ready. Stored lane valid = in_lane_vld[i] & ~in_nop[i];
//    stored lane payload = in_payload lane if valid, else all-zero (instr 0 = bubble).
//  - Release = out_valid & out_ready. Latency: accept in EMPTY -> out_valid next cycle.
//  - FSM (main/skid occupancy):
//    EMPTY: accept -> FULL (load main).
//    FULL : accept&release -> FULL (main<=in); accept&!release -> SKID (skid<=in);
//           release&!accept -> EMPTY; else hold.
//    SKID : in_ready=0; release -> FULL (main<=skid, skid cleared); else hold (stall).
//  - Stall (out_ready=0) holds main and skid bit-exact; no entry is overwritten or lost.
//  - flush: highest priority, synchronous. Next cycle: EMPTY, both entries zero,
//    out_valid=0, in_ready=1. A group offered in the flush cycle is dropped; release in
//    the flush cycle is still counted as consumed by EX1.
//  - flush + in_nop same cycle: flush wins. All-lanes-killed group is still accepted and
//    presented (out_valid=1, out_lane_vld=0) so group ordering is preserved.
//  - rstn low mid-operation: immediate clear to reset values regardless of state.
//  - Group is atomic: lanes never advance independently.
// CONFIGURATION
//  ISSUE_PERF_CNT_EN defined: three CNT_W wrap-around counters as above, cleared only by
//    rstn (not by flush); perf_kill_cnt adds popcount(in_lane_vld & in_nop) per accept.
//  ISSUE_PERF_CNT_EN undefined: perf_* ports and counter logic absent; datapath identical.
// STRUCTURE
//  - Shared header issue_defs.vh: ISSUE_PAY_INSTR/IMM/RS1/RS2/RD/PC/BP field offsets,
//    PAY_W formula, FSM state encodings ISSUE_ST_EMPTY/FULL/SKID.
//  - Sub-module issue_pipe_entry: one LANES-wide entry register (lane valid + zero-on-kill
//    payload, load/clear controls); instantiated twice (main, skid). Top holds FSM + counters.
// TESTING
//  1 Reset: rstn=0 mid-traffic -> out_valid=0, out_payload=0, in_ready=1, counters=0.
//  2 Pass-through: out_ready=1, groups pc=0x100,0x108,0x110 each cycle -> appear 1 cycle
//    later in order, in_ready stays 1, no skid use.
//  3 Stall: group A accepted, out_ready=0, group B offered -> B in skid, in_ready=0 next
//    cycle, A held 5 cycles; out_ready=1 -> A then B released, in_ready=1 after B moves.
//  4 Kill: in_lane_vld=2'b11, in_nop=2'b01 -> out_lane_vld=2'b10, lane0 payload all zero,
//    perf_kill_cnt +1 (EN build).
//  5 Flush in SKID with in_valid=1 -> next cycle out_valid=0, in_ready=1, both entries
//    zero, offered group never appears.
//  6 LANES=4, DATA_W=32 build: random valid/ready/nop/flush 10k cycles vs scoreboard
//    -> no loss, no duplication, order preserved; EN and non-EN builds match on datapath.

Source files
------------

// File: rtl/issue_ex_pipe_stage_pkg.sv
// Shared definitions for the issue->EX pipeline stage: per-lane payload field
// offsets, payload width formula and main/skid occupancy state encodings.
package issue_ex_pipe_stage_pkg;

    // Occupancy of the two-entry (main + skid) buffer
    typedef enum logic [1:0] {
        ISSUE_ST_EMPTY = 2'd0,
        ISSUE_ST_FULL  = 2'd1,
        ISSUE_ST_SKID  = 2'd2
    } issue_state_e;

    // Per-lane payload: instr | imm | pc (DATA_W each), rs1 | rs2 | rd (REG_W each), bp (1)
    function automatic int issue_pay_w(input int data_w, input int reg_w);
        return 3 * data_w + 3 * reg_w + 1;
    endfunction

    function automatic int issue_pay_instr(input int data_w, input int reg_w);
        return 0 * data_w + 0 * reg_w;
    endfunction

    function automatic int issue_pay_imm(input int data_w, input int reg_w);
        return data_w + 0 * reg_w;
    endfunction

    function automatic int issue_pay_pc(input int data_w, input int reg_w);
        return 2 * data_w + 0 * reg_w;
    endfunction

    function automatic int issue_pay_rs1(input int data_w, input int reg_w);
        return 3 * data_w + 0 * reg_w;
    endfunction

    function automatic int issue_pay_rs2(input int data_w, input int reg_w);
        return 3 * data_w + reg_w;
    endfunction

    function automatic int issue_pay_rd(input int data_w, input int reg_w);
        return 3 * data_w + 2 * reg_w;
    endfunction

    function automatic int issue_pay_bp(input int data_w, input int reg_w);
        return 3 * data_w + 3 * reg_w;
    endfunction

endpackage

// File: rtl/issue_pipe_entry.sv
// One LANES-wide pipeline entry: per-lane valid bit plus payload. A lane that
// is loaded without its valid bit stores an all-zero payload (instr 0 = bubble).
// clr has priority over load.
module issue_pipe_entry #(
    parameter int LANES = 2,
    parameter int PAY_W = 112
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   load,
    input  logic [LANES-1:0]       in_lane_vld,
    input  logic [LANES*PAY_W-1:0] in_payload,
    output logic [LANES-1:0]       lane_vld,
    output logic [LANES*PAY_W-1:0] payload
);

    logic [LANES-1:0]       lane_vld_d, lane_vld_q;
    logic [LANES*PAY_W-1:0] payload_d,  payload_q;

    // Next-entry selection: clear, load (zeroing killed/absent lanes) or hold
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        lane_vld_d = lane_vld_q;
        payload_d  = payload_q;
        if (clr) begin
            lane_vld_d = '0;
            payload_d  = '0;
        end else if (load) begin
            lane_vld_d = in_lane_vld;
            for (int i = 0; i < LANES; i++) begin
                payload_d[i*PAY_W +: PAY_W] = in_lane_vld[i] ? in_payload[i*PAY_W +: PAY_W] : '0;
            end
        end
    end

    // Entry register
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the payload is reset too (not just the valid bits) because a
        // downstream lane must read zero whenever it is not valid, including right after reset.
        if (!rstn) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            lane_vld_q <= '0;
            payload_q  <= '0;
        end else begin
            lane_vld_q <= lane_vld_d;
            payload_q  <= payload_d;
        end
    end

    assign lane_vld = lane_vld_q;
    assign payload  = payload_q;

endmodule

// File: rtl/issue_ex_pipe_stage.sv
// Issue->EX1 pipeline stage: valid/ready handshake with a main + skid entry,
// per-lane kill and per-lane valid. Groups move atomically.
// Optional feature macro: ISSUE_PERF_CNT_EN adds stall/bubble/kill counters.
module issue_ex_pipe_stage
    import issue_ex_pipe_stage_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
`ifdef ISSUE_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic                                           flush,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [LANES-1:0]                               in_lane_vld,
    input  logic [LANES-1:0]                               in_nop,
    input  logic [LANES*issue_pay_w(DATA_W, REG_W)-1:0]    in_payload,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [LANES-1:0]                               out_lane_vld,
    output logic [LANES*issue_pay_w(DATA_W, REG_W)-1:0]    out_payload
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                               perf_stall_cnt,
    output logic [CNT_W-1:0]                               perf_bubble_cnt,
    output logic [CNT_W-1:0]                               perf_kill_cnt
`endif
);

    localparam int PAY_W = issue_pay_w(DATA_W, REG_W);

    issue_state_e           state_d, state_q;
    logic                   accept, release_grp;
    logic                   main_load, main_from_skid, main_clr;
    logic                   skid_load, skid_clr;
    logic [LANES-1:0]       in_vld_eff, skid_lane_vld, main_in_vld;
    logic [LANES*PAY_W-1:0] skid_payload, main_in_payload;

    assign in_ready    = (state_q != ISSUE_ST_SKID);
    assign out_valid   = (state_q != ISSUE_ST_EMPTY);
    assign accept      = in_valid & in_ready & ~flush;
    assign release_grp = out_valid & out_ready;
    assign in_vld_eff  = in_lane_vld & ~in_nop;

    // Occupancy FSM next state and entry load/clear controls; flush dominates
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = ISSUE_ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ISSUE_ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ISSUE_ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ISSUE_ST_FULL: begin
                    if (accept && release_grp) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = ISSUE_ST_SKID;
                        skid_load = 1'b1;
                    end else if (release_grp) begin
                        state_d  = ISSUE_ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ISSUE_ST_SKID: begin
                    if (release_grp) begin
                        state_d        = ISSUE_ST_FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: state_d = ISSUE_ST_EMPTY;
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ISSUE_ST_EMPTY;
        else       state_q <= state_d;
    end

    // Main entry refills from the skid entry when one is waiting, else from upstream
    assign main_in_vld     = main_from_skid ? skid_lane_vld : in_vld_eff;
    assign main_in_payload = main_from_skid ? skid_payload  : in_payload;

    issue_pipe_entry #(.LANES(LANES), .PAY_W(PAY_W)) u_main (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (main_clr),
        .load        (main_load),
        .in_lane_vld (main_in_vld),
        .in_payload  (main_in_payload),
        .lane_vld    (out_lane_vld),
        .payload     (out_payload)
    );

    issue_pipe_entry #(.LANES(LANES), .PAY_W(PAY_W)) u_skid (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (skid_clr),
        .load        (skid_load),
        .in_lane_vld (in_vld_eff),
        .in_payload  (in_payload),
        .lane_vld    (skid_lane_vld),
        .payload     (skid_payload)
    );

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0] kill_cnt_d, kill_cnt_q;
    logic [CNT_W-1:0] kill_pop;

    // Counter increments; kills count only for groups actually accepted
    always_comb begin
        kill_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            kill_pop = kill_pop + CNT_W'(in_lane_vld[i] & in_nop[i]);
        end
        stall_cnt_d  = stall_cnt_q  + CNT_W'(out_valid & ~out_ready);
        bubble_cnt_d = bubble_cnt_q + CNT_W'(~out_valid);
        kill_cnt_d   = accept ? kill_cnt_q + kill_pop : kill_cnt_q;
    end

    // Wrap-around counters, cleared only by reset (flush does not touch them)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            kill_cnt_q   <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            kill_cnt_q   <= kill_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_kill_cnt   = kill_cnt_q;
`endif

endmodule

// File: tb/tb_issue_ex_pipe_stage.sv
// Directed self-checking bench for issue_ex_pipe_stage (LANES=2, DATA_W=32, REG_W=5).
// Counter checks are compiled in only when ISSUE_PERF_CNT_EN is defined.
module tb_issue_ex_pipe_stage;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int PAY_W  = 112;   // 3*32 + 3*5 + 1
    localparam int CNT_W  = 32;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES-1:0]       in_lane_vld = '0;
    logic [LANES-1:0]       in_nop = '0;
    logic [LANES*PAY_W-1:0] in_payload = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [LANES-1:0]       out_lane_vld;
    logic [LANES*PAY_W-1:0] out_payload;
`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0]       perf_stall_cnt, perf_bubble_cnt, perf_kill_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    issue_ex_pipe_stage #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane_vld  (in_lane_vld),
        .in_nop       (in_nop),
        .in_payload   (in_payload),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane_vld (out_lane_vld),
        .out_payload  (out_payload)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_kill_cnt   (perf_kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Hand-placed lane fields: instr[31:0] imm[63:32] pc[95:64] rs1[100:96] rs2[105:101] rd[110:106] bp[111]
    function automatic logic [PAY_W-1:0] mk_lane(input logic [31:0] pc);
        logic [PAY_W-1:0] p;
        p = '0;
        p[31:0]    = 32'h0000_0013 | (pc << 8);
        p[63:32]   = pc ^ 32'h5A5A_A5A5;
        p[95:64]   = pc;
        p[100:96]  = pc[6:2];
        p[105:101] = pc[7:3];
        p[110:106] = 5'h1F;
        p[111]     = 1'b1;
        return p;
    endfunction

    function automatic logic [LANES*PAY_W-1:0] mk_grp(input logic [31:0] pc);
        return {mk_lane(pc + 32'd4), mk_lane(pc)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [1:0] lv, input logic [1:0] nop);
        in_valid    = 1'b1;
        in_lane_vld = lv;
        in_nop      = nop;
        in_payload  = mk_grp(pc);
    endtask

    task automatic idle_in();
        in_valid    = 1'b0;
        in_lane_vld = '0;
        in_nop      = '0;
        in_payload  = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_lane_vld !== 2'b00 || out_payload !== '0) begin
            $display("FAIL reset_state: out_valid=%b in_ready=%b lane_vld=%b pay_nz=%b want 0/1/00/0",
                     out_valid, in_ready, out_lane_vld, |out_payload);
        end else n_pass++;
`ifdef ISSUE_PERF_CNT_EN
        n_total++;
        if (perf_stall_cnt !== 0 || perf_bubble_cnt !== 0 || perf_kill_cnt !== 0) begin
            $display("FAIL reset_counters: stall=%0d bubble=%0d kill=%0d want 0/0/0",
                     perf_stall_cnt, perf_bubble_cnt, perf_kill_cnt);
        end else n_pass++;
`endif
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_pass_through();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h108; pcs[2] = 32'h110;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            offer(pcs[k], 2'b11, 2'b00);
            step();
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_lane_vld !== 2'b11 || out_payload !== mk_grp(pcs[k])) begin
                $display("FAIL pass_through[%0d]: out_valid=%b in_ready=%b lane_vld=%b pc0=%h want 1/1/11 pc0=%h",
                         k, out_valid, in_ready, out_lane_vld, out_payload[95:64], pcs[k]);
            end else n_pass++;
        end
        idle_in();
        step();
        n_total++;
        if (out_valid !== 1'b0 || out_payload !== '0) begin
            $display("FAIL pass_through_drain: out_valid=%b pay_nz=%b want 0/0", out_valid, |out_payload);
        end else n_pass++;
    endtask

    task automatic test_stall();
`ifdef ISSUE_PERF_CNT_EN
        logic [CNT_W-1:0] stall0;
        stall0 = perf_stall_cnt;
`endif
        out_ready = 1'b0;
        offer(32'h300, 2'b11, 2'b00);   // A
        step();
        n_total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_payload !== mk_grp(32'h300)) begin
            $display("FAIL stall_load_a: out_valid=%b in_ready=%b pc0=%h want 1/1 pc0=300",
                     out_valid, in_ready, out_payload[95:64]);
        end else n_pass++;
        offer(32'h400, 2'b11, 2'b00);   // B goes to skid
        step();
        idle_in();
        n_total++;
        if (in_ready !== 1'b0 || out_payload !== mk_grp(32'h300)) begin
            $display("FAIL stall_skid: in_ready=%b pc0=%h want 0 pc0=300", in_ready, out_payload[95:64]);
        end else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step();
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_lane_vld !== 2'b11 || out_payload !== mk_grp(32'h300)) begin
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b lane_vld=%b pc0=%h want 1/0/11 pc0=300",
                         k, out_valid, in_ready, out_lane_vld, out_payload[95:64]);
            end else n_pass++;
        end
`ifdef ISSUE_PERF_CNT_EN
        n_total++;
        if (perf_stall_cnt - stall0 !== 5) begin
            $display("FAIL stall_counter: delta=%0d want 5", perf_stall_cnt - stall0);
        end else n_pass++;
`endif
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_payload !== mk_grp(32'h400)) begin
            $display("FAIL stall_release_b: out_valid=%b in_ready=%b pc0=%h want 1/1 pc0=400",
                     out_valid, in_ready, out_payload[95:64]);
        end else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stall_drain: out_valid=%b want 0", out_valid);
        end else n_pass++;
    endtask

    task automatic test_kill();
        logic [LANES*PAY_W-1:0] exp;
`ifdef ISSUE_PERF_CNT_EN
        logic [CNT_W-1:0] kill0;
        kill0 = perf_kill_cnt;
`endif
        out_ready = 1'b1;
        offer(32'h200, 2'b11, 2'b01);
        step();
        exp = {mk_lane(32'h204), {PAY_W{1'b0}}};
        n_total++;
        if (out_valid !== 1'b1 || out_lane_vld !== 2'b10 || out_payload !== exp) begin
            $display("FAIL kill_lane0: out_valid=%b lane_vld=%b lane0_nz=%b pc1=%h want 1/10/0 pc1=204",
                     out_valid, out_lane_vld, |out_payload[PAY_W-1:0], out_payload[PAY_W+64 +: 32]);
        end else n_pass++;
        offer(32'h210, 2'b11, 2'b11);   // every lane killed: group still presented
        step();
        n_total++;
        if (out_valid !== 1'b1 || out_lane_vld !== 2'b00 || out_payload !== '0) begin
            $display("FAIL kill_all: out_valid=%b lane_vld=%b pay_nz=%b want 1/00/0",
                     out_valid, out_lane_vld, |out_payload);
        end else n_pass++;
        offer(32'h220, 2'b01, 2'b00);   // lane1 absent
        step();
        exp = {{PAY_W{1'b0}}, mk_lane(32'h220)};
        n_total++;
        if (out_lane_vld !== 2'b01 || out_payload !== exp) begin
            $display("FAIL absent_lane1: lane_vld=%b lane1_nz=%b want 01/0",
                     out_lane_vld, |out_payload[LANES*PAY_W-1:PAY_W]);
        end else n_pass++;
        idle_in();
        step();
`ifdef ISSUE_PERF_CNT_EN
        n_total++;
        if (perf_kill_cnt - kill0 !== 3) begin
            $display("FAIL kill_counter: delta=%0d want 3", perf_kill_cnt - kill0);
        end else n_pass++;
`endif
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h500, 2'b11, 2'b00);
        step();
        offer(32'h600, 2'b11, 2'b00);
        step();
        offer(32'h700, 2'b11, 2'b10);   // offered during flush: must be dropped
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_lane_vld !== 2'b00 || out_payload !== '0) begin
            $display("FAIL flush_clear: out_valid=%b in_ready=%b lane_vld=%b pay_nz=%b want 0/1/00/0",
                     out_valid, in_ready, out_lane_vld, |out_payload);
        end else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL flush_no_ghost: out_valid=%b pc0=%h want 0", out_valid, out_payload[95:64]);
        end else n_pass++;
        offer(32'h800, 2'b11, 2'b00);
        step();
        idle_in();
        n_total++;
        if (out_valid !== 1'b1 || out_payload !== mk_grp(32'h800)) begin
            $display("FAIL flush_recover: out_valid=%b pc0=%h want 1 pc0=800", out_valid, out_payload[95:64]);
        end else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL flush_stale_skid: out_valid=%b pc0=%h want 0", out_valid, out_payload[95:64]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(32'h900, 2'b11, 2'b00);
        step();
        offer(32'hA00, 2'b11, 2'b00);
        step();
        idle_in();
        #2;
        rstn = 1'b0;                     // asynchronous, between clock edges
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_lane_vld !== 2'b00 || out_payload !== '0) begin
            $display("FAIL reset_mid: out_valid=%b in_ready=%b lane_vld=%b pay_nz=%b want 0/1/00/0",
                     out_valid, in_ready, out_lane_vld, |out_payload);
        end else n_pass++;
`ifdef ISSUE_PERF_CNT_EN
        n_total++;
        if (perf_stall_cnt !== 0 || perf_bubble_cnt !== 0 || perf_kill_cnt !== 0) begin
            $display("FAIL reset_mid_counters: stall=%0d bubble=%0d kill=%0d want 0/0/0",
                     perf_stall_cnt, perf_bubble_cnt, perf_kill_cnt);
        end else n_pass++;
`endif
        step();
        rstn = 1'b1;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_mid_after: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall();
        test_kill();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
